// File: rtl/fm_sb_seq.sv
// rtl/fm_sb_seq.sv - spy-buffer init/arm/freeze/playback sequencer
module fm_sb_seq #(
    parameter int SB_N        = 27,
    parameter int PB_MODE_W   = 2,
    parameter int INIT_CYCLES = 16
) (
    input  logic                 axi_clk,
    input  logic                 axi_reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [SB_N-1:0]      cmd_mask,
    input  logic [PB_MODE_W-1:0] cmd_mode,
    input  logic [15:0]          cmd_post,
    input  logic                 trigger,
    output logic [SB_N-1:0]      freeze,
    output logic [PB_MODE_W-1:0] playback_mode [SB_N],
    output logic                 init_spy_mem,
    output logic [2:0]           state,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           err_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT     = 3'd1,
        S_ARMED    = 3'd2,
        S_POST     = 3'd3,
        S_FROZEN   = 3'd4,
        S_PLAYBACK = 3'd5
    } state_e;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_INIT    = 3'd1;
    localparam logic [2:0] OP_ARM     = 3'd2;
    localparam logic [2:0] OP_FREEZE  = 3'd3;
    localparam logic [2:0] OP_RELEASE = 3'd4;
    localparam logic [2:0] OP_PLAY    = 3'd5;
    localparam logic [2:0] OP_STOP    = 3'd6;

    state_e                 state_q, state_d;
    logic [SB_N-1:0]        mask_q, mask_d;
    logic [PB_MODE_W-1:0]   mode_q, mode_d;
    logic [15:0]            post_q, post_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [7:0]             init_cnt_q, init_cnt_d;
    logic [SB_N-1:0]        freeze_q, freeze_d;
    logic [PB_MODE_W-1:0]   pm_q [SB_N];
    logic [PB_MODE_W-1:0]   pm_d [SB_N];
    logic                   init_q, init_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [7:0]             err_count_q, err_count_d;
    logic                   cmd_acc;
    logic                   cmd_ok;

    assign cmd_ready     = (state_q != S_INIT);
    assign cmd_acc       = cmd_valid & cmd_ready;
    assign freeze        = freeze_q;
    assign playback_mode = pm_q;
    assign init_spy_mem  = init_q;
    assign state         = state_q;
    assign done          = done_q;
    assign err           = err_q;
    assign err_count     = err_count_q;

    // Next-state: commands first, then trigger / post-count / init timing when no command moved the FSM
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        mode_d     = mode_q;
        post_d     = post_q;
        cnt_d      = cnt_q;
        init_cnt_d = init_cnt_q;
        cmd_ok     = (cmd_op == OP_NOP);

        case (state_q)
            S_IDLE: begin
                if (cmd_acc) begin
                    if (cmd_op == OP_INIT) begin
                        cmd_ok     = 1'b1;
                        state_d    = S_INIT;
                        init_cnt_d = 8'(INIT_CYCLES);
                    end else if (cmd_op == OP_ARM && |cmd_mask) begin
                        cmd_ok  = 1'b1;
                        state_d = S_ARMED;
                        mask_d  = cmd_mask;
                        post_d  = cmd_post;
                    end else if (cmd_op == OP_PLAY && |cmd_mask) begin
                        cmd_ok  = 1'b1;
                        state_d = S_PLAYBACK;
                        mask_d  = cmd_mask;
                        mode_d  = cmd_mode;
                    end
                end
            end
            S_INIT: begin
                if (init_cnt_q <= 8'd1) begin
                    state_d    = S_IDLE;
                    init_cnt_d = 8'd0;
                end else begin
                    init_cnt_d = init_cnt_q - 8'd1;
                end
            end
            S_ARMED, S_POST: begin
                if (cmd_acc && cmd_op == OP_FREEZE) begin
                    cmd_ok  = 1'b1;
                    state_d = S_FROZEN;
                    cnt_d   = 16'd0;
                end else if (cmd_acc && cmd_op == OP_RELEASE) begin
                    cmd_ok  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                end else if (state_q == S_ARMED) begin
                    if (trigger) begin
                        if (post_q == 16'd0) begin
                            state_d = S_FROZEN;
                        end else begin
                            state_d = S_POST;
                            cnt_d   = post_q;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = S_FROZEN;
                    end
                end
            end
            S_FROZEN: begin
                if (cmd_acc && cmd_op == OP_RELEASE) begin
                    cmd_ok  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_PLAYBACK: begin
                if (cmd_acc && cmd_op == OP_STOP) begin
                    cmd_ok  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output next-values are derived from the next state so every output is registered
    always_comb begin
        freeze_d = (state_d == S_FROZEN) ? mask_d : '0;
        for (int i = 0; i < SB_N; i++) begin
            pm_d[i] = (state_d == S_PLAYBACK && mask_d[i]) ? mode_d : '0;
        end
        init_d = (state_d == S_INIT);
        done_d = (state_d == S_FROZEN && state_q != S_FROZEN) ||
                 (state_q == S_INIT && state_d == S_IDLE);
        err_d  = cmd_acc & ~cmd_ok;
        err_count_d = (err_d && err_count_q != 8'hff) ? err_count_q + 8'd1 : err_count_q;
    end

    // State, latched command fields, counters and registered outputs
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            mode_q      <= '0;
            post_q      <= '0;
            cnt_q       <= '0;
            init_cnt_q  <= '0;
            freeze_q    <= '0;
            for (int i = 0; i < SB_N; i++) begin
                pm_q[i] <= '0;
            end
            init_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            post_q      <= post_d;
            cnt_q       <= cnt_d;
            init_cnt_q  <= init_cnt_d;
            freeze_q    <= freeze_d;
            for (int i = 0; i < SB_N; i++) begin
                pm_q[i] <= pm_d[i];
            end
            init_q      <= init_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_fm_sb_seq.sv
// tb/tb_fm_sb_seq.sv - self-checking bench for fm_sb_seq
module tb_fm_sb_seq;

    localparam int SB_N        = 27;
    localparam int PB_MODE_W   = 2;
    localparam int INIT_CYCLES = 16;

    logic                 axi_clk     = 1'b0;
    logic                 axi_reset_n = 1'b0;
    logic                 cmd_valid   = 1'b0;
    logic                 cmd_ready;
    logic [2:0]           cmd_op      = '0;
    logic [SB_N-1:0]      cmd_mask    = '0;
    logic [PB_MODE_W-1:0] cmd_mode    = '0;
    logic [15:0]          cmd_post    = '0;
    logic                 trigger     = 1'b0;
    logic [SB_N-1:0]      freeze;
    logic [PB_MODE_W-1:0] playback_mode [SB_N];
    logic                 init_spy_mem;
    logic [2:0]           state;
    logic                 done;
    logic                 err;
    logic [7:0]           err_count;

    int checks = 0;
    int errors = 0;
    bit run    = 1'b0;

    fm_sb_seq #(.SB_N(SB_N), .PB_MODE_W(PB_MODE_W), .INIT_CYCLES(INIT_CYCLES)) dut (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_mask(cmd_mask), .cmd_mode(cmd_mode), .cmd_post(cmd_post),
        .trigger(trigger), .freeze(freeze), .playback_mode(playback_mode),
        .init_spy_mem(init_spy_mem), .state(state), .done(done), .err(err),
        .err_count(err_count)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phases and absolute deadlines (cycle numbers) rather than counters
    int              cyc      = 0;
    int              m_state  = 0;
    logic [SB_N-1:0] m_mask   = '0;
    logic [1:0]      m_mode   = '0;
    int              m_post   = 0;
    int              init_end = 0;
    int              frz_at   = 0;
    bit              m_done   = 1'b0;
    bit              m_err    = 1'b0;
    int              m_errcnt = 0;
    bit              m_acc, m_ok;
    int              m_op, m_nxt;

    always @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            m_state = 0; m_mask = '0; m_mode = '0; m_post = 0;
            m_done = 0; m_err = 0; m_errcnt = 0;
        end else begin
            cyc++;
            m_acc = cmd_valid && (m_state != 1);
            m_op  = int'(cmd_op);
            m_nxt = m_state;
            m_ok  = (m_op == 0);
            m_done = 0;
            if (m_acc && m_op != 0) begin
                if (m_state == 0 && m_op == 1) begin
                    m_ok = 1; m_nxt = 1; init_end = cyc + INIT_CYCLES;
                end else if (m_state == 0 && m_op == 2 && cmd_mask != 0) begin
                    m_ok = 1; m_nxt = 2; m_mask = cmd_mask; m_post = int'(cmd_post);
                end else if (m_state == 0 && m_op == 5 && cmd_mask != 0) begin
                    m_ok = 1; m_nxt = 5; m_mask = cmd_mask; m_mode = cmd_mode;
                end else if ((m_state == 2 || m_state == 3) && m_op == 3) begin
                    m_ok = 1; m_nxt = 4;
                end else if ((m_state == 2 || m_state == 3 || m_state == 4) && m_op == 4) begin
                    m_ok = 1; m_nxt = 0;
                end else if (m_state == 5 && m_op == 6) begin
                    m_ok = 1; m_nxt = 0;
                end
            end
            if (m_nxt == m_state) begin
                if (m_state == 2 && trigger) begin
                    if (m_post == 0) m_nxt = 4;
                    else begin m_nxt = 3; frz_at = cyc + m_post; end
                end else if (m_state == 3 && cyc == frz_at) begin
                    m_nxt = 4;
                end else if (m_state == 1 && cyc == init_end) begin
                    m_nxt = 0; m_done = 1;
                end
            end
            if (m_nxt == 4 && m_state != 4) m_done = 1;
            m_err = m_acc && !m_ok;
            if (m_err && m_errcnt < 255) m_errcnt++;
            m_state = m_nxt;
        end
    end

    logic [SB_N*PB_MODE_W-1:0] pm_act, pm_exp;
    always_comb begin
        pm_act = '0;
        pm_exp = '0;
        for (int i = 0; i < SB_N; i++) begin
            pm_act[i*PB_MODE_W +: PB_MODE_W] = playback_mode[i];
            pm_exp[i*PB_MODE_W +: PB_MODE_W] = (m_state == 5 && m_mask[i]) ? m_mode : 2'd0;
        end
    end

    // Compare process: every output against the model, away from the active edge
    always @(negedge axi_clk) begin
        if (run) begin
            chk("state", 64'(state), 64'(m_state));
            chk("cmd_ready", 64'(cmd_ready), 64'(m_state != 1));
            chk("freeze", 64'(freeze), 64'((m_state == 4) ? m_mask : '0));
            chk("playback_mode", 64'(pm_act), 64'(pm_exp));
            chk("init_spy_mem", 64'(init_spy_mem), 64'(m_state == 1));
            chk("done", 64'(done), 64'(m_done));
            chk("err", 64'(err), 64'(m_err));
            chk("err_count", 64'(err_count), 64'(m_errcnt));
        end
    end

    task automatic send(input logic [2:0] op, input logic [SB_N-1:0] m,
                        input logic [1:0] md, input logic [15:0] p);
        cmd_valid = 1'b1; cmd_op = op; cmd_mask = m; cmd_mode = md; cmd_post = p;
        @(negedge axi_clk);
        cmd_valid = 1'b0; cmd_op = '0; cmd_mask = '0; cmd_mode = '0; cmd_post = '0;
    endtask

    task automatic pulse_trig();
        trigger = 1'b1;
        @(negedge axi_clk);
        trigger = 1'b0;
    endtask

    initial begin
        run = 1'b1;
        repeat (2) @(negedge axi_clk);
        chk("rst state", 64'(state), 64'd0);
        chk("rst err_count", 64'(err_count), 64'd0);
        axi_reset_n = 1'b1;

        // INIT: pulse width and done timing
        send(3'd1, '0, '0, '0);
        chk("init high first", 64'(init_spy_mem), 64'd1);
        chk("init ready low", 64'(cmd_ready), 64'd0);
        repeat (INIT_CYCLES - 1) @(negedge axi_clk);
        chk("init high last", 64'(init_spy_mem), 64'd1);
        @(negedge axi_clk);
        chk("init dropped", 64'(init_spy_mem), 64'd0);
        chk("init done", 64'(done), 64'd1);
        chk("init idle", 64'(state), 64'd0);

        // ARM mask 5 post 3, trigger, freeze three cycles later, then RELEASE
        send(3'd2, 27'h5, '0, 16'd3);
        pulse_trig();
        repeat (2) @(negedge axi_clk);
        chk("post not yet", 64'(freeze), 64'd0);
        @(negedge axi_clk);
        chk("post freeze", 64'(freeze), 64'h5);
        chk("post done", 64'(done), 64'd1);
        send(3'd4, '0, '0, '0);
        chk("release freeze", 64'(freeze), 64'd0);

        // ARM post 0, trigger and FREEZE together
        send(3'd2, 27'h3, '0, 16'd0);
        trigger = 1'b1;
        send(3'd3, '0, '0, '0);
        trigger = 1'b0;
        chk("coinc freeze", 64'(freeze), 64'h3);
        chk("coinc err", 64'(err), 64'd0);
        @(negedge axi_clk);
        chk("coinc single done", 64'(done), 64'd0);
        send(3'd4, '0, '0, '0);

        // PLAY then illegal ARM
        send(3'd5, 27'h2, 2'd2, '0);
        chk("pm1", 64'(playback_mode[1]), 64'd2);
        chk("pm0", 64'(playback_mode[0]), 64'd0);
        send(3'd2, 27'h1, '0, 16'd1);
        chk("play err", 64'(err), 64'd1);
        chk("play err_count", 64'(err_count), 64'd1);
        chk("play state", 64'(state), 64'd5);
        send(3'd6, '0, '0, '0);

        // Trigger in IDLE is ignored
        pulse_trig();
        chk("idle trig", 64'(state), 64'd0);

        // Async reset in POST with counter at 100
        send(3'd2, 27'h1, '0, 16'd200);
        pulse_trig();
        repeat (100) @(negedge axi_clk);
        chk("in post", 64'(state), 64'd3);
        #1 axi_reset_n = 1'b0;
        #1;
        chk("async state", 64'(state), 64'd0);
        chk("async err_count", 64'(err_count), 64'd0);
        chk("async freeze", 64'(freeze), 64'd0);
        chk("async done", 64'(done), 64'd0);
        @(negedge axi_clk);
        axi_reset_n = 1'b1;
        chk("ready after rst", 64'(cmd_ready), 64'd1);
        send(3'd5, 27'h4000001, 2'd1, '0);
        chk("first-edge cmd", 64'(state), 64'd5);
        send(3'd6, '0, '0, '0);

        // Illegal commands and saturation
        send(3'd3, '0, '0, '0);
        chk("freeze in idle err", 64'(err), 64'd1);
        send(3'd2, '0, '0, 16'd4);
        chk("zero mask err", 64'(err_count), 64'd2);
        cmd_valid = 1'b1; cmd_op = 3'd7;
        repeat (260) @(negedge axi_clk);
        cmd_valid = 1'b0; cmd_op = '0;
        chk("saturate", 64'(err_count), 64'd255);
        repeat (3) @(negedge axi_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
